// File: rtl/dcache_types.sv
// Shared types and geometry for the direct-mapped, write-back data cache.
package dcache_types;
  localparam int S_OFFSET = 5;
  localparam int S_INDEX  = 3;
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int SETS     = 1 << S_INDEX;

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    FILL
  } dcache_state_t;

  typedef logic [S_TAG-1:0]   tag_t;
  typedef logic [S_INDEX-1:0] index_t;
  typedef logic [255:0]       line_t;
endpackage

// File: rtl/dcache_array.sv
// Flip-flop storage array with combinational read and lane-masked write;
// optionally cleared by the asynchronous reset (used for valid/dirty bits).
module dcache_array #(
  parameter int WIDTH       = 1,
  parameter int DEPTH       = 8,
  parameter int MASK_W      = 1,
  parameter bit ASYNC_RESET = 1'b0,
  localparam int AW         = $clog2(DEPTH),
  localparam int LANE       = WIDTH / MASK_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [MASK_W-1:0] wmask,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  generate
    if (ASYNC_RESET) begin : g_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
        end else if (we) begin
          for (int i = 0; i < MASK_W; i++)
            if (wmask[i]) mem[addr][i*LANE +: LANE] <= wdata[i*LANE +: LANE];
        end
      end
    end else begin : g_norst
      logic unused_rst;
      assign unused_rst = rst;
      always_ff @(posedge clk) begin
        if (we) begin
          for (int i = 0; i < MASK_W; i++)
            if (wmask[i]) mem[addr][i*LANE +: LANE] <= wdata[i*LANE +: LANE];
        end
      end
    end
  endgenerate
endmodule

// File: rtl/dcache_responder.sv
// MEM-stage data cache: direct-mapped, write-back, write-allocate, with a
// 256-bit line-granular pmem port. Hits complete in the cycle they are seen.
module dcache_responder
  import dcache_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_wdata,
  input  logic [3:0]   mem_byte_enable,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);
  dcache_state_t state;
  tag_t   req_tag, miss_tag, tag_q;
  index_t req_index, miss_index, arr_index;
  logic [2:0]  word;
  line_t line_q, data_wdata;
  logic [31:0] data_mask, hit_mask;
  logic valid_q, dirty_q, hit, req, write_hit, fill_done;
  logic unused_bits;

  assign req_tag     = mem_address[31:8];
  assign req_index   = mem_address[7:5];
  assign word        = mem_address[4:2];
  assign unused_bits = ^mem_address[1:0];

  // During a miss the arrays are addressed by the latched miss index.
  assign arr_index = (state == CHECK) ? req_index : miss_index;
  assign req       = mem_read | mem_write;
  assign hit       = valid_q && (tag_q == req_tag);
  assign mem_resp  = (state == CHECK) && req && hit;
  assign write_hit = mem_resp && mem_write;
  assign fill_done = (state == FILL) && pmem_resp;

  assign mem_rdata  = line_q[{word, 5'b0} +: 32];
  assign hit_mask   = {28'b0, mem_byte_enable} << {word, 2'b00};
  assign data_mask  = fill_done ? '1 : hit_mask;
  assign data_wdata = fill_done ? pmem_rdata : {8{mem_wdata}};

  assign pmem_wdata   = line_q;
  assign pmem_address = (state == WRITEBACK) ? {tag_q, miss_index, {S_OFFSET{1'b0}}}
                                             : {miss_tag, miss_index, {S_OFFSET{1'b0}}};

  dcache_array #(.WIDTH(1), .DEPTH(SETS), .MASK_W(1), .ASYNC_RESET(1'b1)) u_valid (
    .clk(clk), .rst(rst), .we(fill_done), .addr(arr_index), .wmask(1'b1),
    .wdata(1'b1), .rdata(valid_q));

  dcache_array #(.WIDTH(1), .DEPTH(SETS), .MASK_W(1), .ASYNC_RESET(1'b1)) u_dirty (
    .clk(clk), .rst(rst), .we(fill_done | (write_hit & |mem_byte_enable)),
    .addr(arr_index), .wmask(1'b1), .wdata(~fill_done), .rdata(dirty_q));

  dcache_array #(.WIDTH(S_TAG), .DEPTH(SETS), .MASK_W(1), .ASYNC_RESET(1'b0)) u_tag (
    .clk(clk), .rst(rst), .we(fill_done), .addr(arr_index), .wmask(1'b1),
    .wdata(miss_tag), .rdata(tag_q));

  dcache_array #(.WIDTH(256), .DEPTH(SETS), .MASK_W(32), .ASYNC_RESET(1'b0)) u_data (
    .clk(clk), .rst(rst), .we(fill_done | write_hit), .addr(arr_index),
    .wmask(data_mask), .wdata(data_wdata), .rdata(line_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CHECK;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      miss_tag   <= '0;
      miss_index <= '0;
    end else begin
      case (state)
        CHECK: begin
          if (req && !hit) begin
            miss_tag   <= req_tag;
            miss_index <= req_index;
            if (valid_q && dirty_q) begin
              state      <= WRITEBACK;
              pmem_write <= 1'b1;
            end else begin
              state     <= FILL;
              pmem_read <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            pmem_write <= 1'b0;
            pmem_read  <= 1'b1;
            state      <= FILL;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            pmem_read <= 1'b0;
            state     <= CHECK;
          end
        end
        default: state <= CHECK;
      endcase
    end
  end

  // A simultaneous read and write is serviced as a write.
  rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write))
    else $warning("dcache_responder: mem_read and mem_write both high, serviced as write");
endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder with a 3-cycle-latency pmem model.
module tb_dcache_responder;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read, mem_write;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // pmem model state and transaction log
  logic [255:0] pm [logic [31:0]];
  int pcnt = 0;
  int n_rd = 0, n_wr = 0;
  int rd_cyc = 0, wr_cyc = 0, resp_cyc = 0;
  logic [31:0]  rd_addr = '0, wr_addr = '0;
  logic [255:0] wr_data = '0;
  bit both_high = 1'b0;

  dcache_responder dut (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_address(pmem_address),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_read && pmem_write) both_high = 1'b1;
      if (rst) begin
        pcnt = 0;
        pmem_resp = 1'b0;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0;
        pcnt = 0;
      end else if (pmem_read || pmem_write) begin
        pcnt++;
        if (pcnt == 3) begin
          pmem_resp = 1'b1;
          resp_cyc = cyc;
          if (pmem_write) begin
            pm[pmem_address] = pmem_wdata;
            n_wr++; wr_addr = pmem_address; wr_data = pmem_wdata; wr_cyc = cyc;
          end else begin
            pmem_rdata = pm.exists(pmem_address) ? pm[pmem_address]
                                                 : {8{pmem_address ^ 32'hA5A50000}};
            n_rd++; rd_addr = pmem_address; rd_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic clear_log();
    n_rd = 0; n_wr = 0;
  endtask

  // Issue one request and hold it until mem_resp; lat = cycles waited.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rdata, output int lat, output int at_cyc);
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
    lat = 0;
    #1;
    while (!mem_resp && lat < 200) begin
      @(negedge clk); #1; lat++;
    end
    rdata = mem_rdata;
    at_cyc = cyc;
    checks++;
    if (!mem_resp) begin
      errors++;
      $display("FAIL access_timeout addr=%h waited=%0d cycles, required mem_resp", addr, lat);
    end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    $display("txn rd=%0b wr=%0b addr=%h wdata=%h be=%b rdata=%h lat=%0d",
             rd, wr, addr, wd, be, rdata, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_read = 0; mem_write = 0; mem_address = '0; mem_wdata = '0;
    mem_byte_enable = '0;
    #1;
    checks++;
    if (mem_resp !== 1'b0) begin errors++; $display("FAIL reset_mem_resp got=%b exp=0", mem_resp); end
    checks++;
    if (pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read got=%b exp=0", pmem_read); end
    checks++;
    if (pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write got=%b exp=0", pmem_write); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cold_read_miss();
    logic [31:0] rd; int lat, at;
    clear_log();
    access(1, 0, 32'h104, 0, 4'h0, rd, lat, at);
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL cold_rdata got=%h exp=deadbeef", rd); end
    checks++;
    if (n_rd != 1 || rd_addr !== 32'h100) begin errors++;
      $display("FAIL cold_fill reads=%0d addr=%h exp 1 read at 00000100", n_rd, rd_addr); end
    checks++;
    if (n_wr != 0) begin errors++; $display("FAIL cold_no_wb writes=%0d exp=0", n_wr); end
    checks++;
    if (at != resp_cyc + 1) begin errors++;
      $display("FAIL cold_latency resp_cycle=%0d exp=%0d", at, resp_cyc + 1); end
  endtask

  task automatic test_write_hit();
    logic [31:0] rd; int lat, at;
    clear_log();
    access(0, 1, 32'h104, 32'h11223344, 4'b0010, rd, lat, at);
    checks++;
    if (lat != 0) begin errors++; $display("FAIL write_hit_latency got=%0d exp=0", lat); end
    access(1, 0, 32'h104, 0, 4'h0, rd, lat, at);
    checks++;
    if (rd !== 32'hDEAD33EF) begin errors++; $display("FAIL write_hit_rdata got=%h exp=dead33ef", rd); end
    checks++;
    if (lat != 0 || n_rd != 0) begin errors++;
      $display("FAIL read_hit lat=%0d fills=%0d exp 0/0", lat, n_rd); end
  endtask

  task automatic test_dirty_eviction();
    logic [31:0] rd; int lat, at;
    clear_log();
    access(1, 0, 32'h1104, 0, 4'h0, rd, lat, at);
    checks++;
    if (n_wr != 1 || wr_addr !== 32'h100) begin errors++;
      $display("FAIL evict_wb writes=%0d addr=%h exp 1 at 00000100", n_wr, wr_addr); end
    checks++;
    if (wr_data[63:32] !== 32'hDEAD33EF) begin errors++;
      $display("FAIL evict_wdata got=%h exp=dead33ef", wr_data[63:32]); end
    checks++;
    if (n_rd != 1 || rd_addr !== 32'h1100 || rd_cyc <= wr_cyc) begin errors++;
      $display("FAIL evict_fill reads=%0d addr=%h rdcyc=%0d wrcyc=%0d exp fill at 00001100 after wb",
               n_rd, rd_addr, rd_cyc, wr_cyc); end
    checks++;
    if (rd !== 32'hA5A51100) begin errors++; $display("FAIL evict_rdata got=%h exp=a5a51100", rd); end
  endtask

  task automatic test_reset_during_fill();
    logic [31:0] rd; int lat, at; int w;
    @(negedge clk);
    mem_read = 1'b1; mem_address = 32'h104; mem_byte_enable = '0;
    w = 0;
    while (!pmem_read && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (!pmem_read) begin errors++; $display("FAIL rstfill_start pmem_read=%b exp=1", pmem_read); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin errors++;
      $display("FAIL rstfill_async pmem_read=%b pmem_write=%b exp 0/0", pmem_read, pmem_write); end
    @(negedge clk); mem_read = 1'b0;
    @(negedge clk); rst = 1'b0;
    clear_log();
    access(1, 0, 32'h104, 0, 4'h0, rd, lat, at);
    checks++;
    if (n_rd != 1 || rd_addr !== 32'h100 || n_wr != 0) begin errors++;
      $display("FAIL rstfill_remiss reads=%0d addr=%h writes=%0d exp 1/00000100/0", n_rd, rd_addr, n_wr); end
    checks++;
    if (rd !== 32'hDEAD33EF) begin errors++; $display("FAIL rstfill_rdata got=%h exp=dead33ef", rd); end
  endtask

  task automatic test_zero_be_write();
    logic [31:0] rd; int lat, at;
    access(0, 1, 32'h108, 32'hFFFFFFFF, 4'b0000, rd, lat, at);
    checks++;
    if (lat != 0) begin errors++; $display("FAIL zero_be_resp lat=%0d exp=0", lat); end
    access(1, 0, 32'h108, 0, 4'h0, rd, lat, at);
    checks++;
    if (rd !== 32'h00000000) begin errors++; $display("FAIL zero_be_data got=%h exp=00000000", rd); end
    clear_log();
    access(1, 0, 32'h2104, 0, 4'h0, rd, lat, at);
    checks++;
    if (n_wr != 0 || n_rd != 1 || rd_addr !== 32'h2100) begin errors++;
      $display("FAIL zero_be_clean writes=%0d reads=%0d addr=%h exp 0/1/00002100", n_wr, n_rd, rd_addr); end
    checks++;
    if (rd !== 32'hA5A52100) begin errors++; $display("FAIL zero_be_fill got=%h exp=a5a52100", rd); end
  endtask

  task automatic test_read_write_both();
    logic [31:0] rd; int lat, at;
    access(1, 1, 32'h2108, 32'hCAFEF00D, 4'b1111, rd, lat, at);
    checks++;
    if (lat != 0) begin errors++; $display("FAIL rw_both_resp lat=%0d exp=0", lat); end
    access(1, 0, 32'h2108, 0, 4'h0, rd, lat, at);
    checks++;
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rw_both_data got=%h exp=cafef00d", rd); end
    clear_log();
    access(1, 0, 32'h3100, 0, 4'h0, rd, lat, at);
    checks++;
    if (n_wr != 1 || wr_addr !== 32'h2100 || wr_data[95:64] !== 32'hCAFEF00D) begin errors++;
      $display("FAIL rw_both_dirty writes=%0d addr=%h word2=%h exp 1/00002100/cafef00d",
               n_wr, wr_addr, wr_data[95:64]); end
  endtask

  task automatic test_write_allocate();
    logic [31:0] rd; int lat, at;
    clear_log();
    access(0, 1, 32'h64, 32'h12345678, 4'b1111, rd, lat, at);
    checks++;
    if (n_rd != 1 || rd_addr !== 32'h60 || n_wr != 0) begin errors++;
      $display("FAIL walloc_fill reads=%0d addr=%h writes=%0d exp 1/00000060/0", n_rd, rd_addr, n_wr); end
    access(1, 0, 32'h64, 0, 4'h0, rd, lat, at);
    checks++;
    if (rd !== 32'h12345678) begin errors++; $display("FAIL walloc_data got=%h exp=12345678", rd); end
    access(1, 0, 32'h60, 0, 4'h0, rd, lat, at);
    checks++;
    if (rd !== 32'hA5A50060 || lat != 0) begin errors++;
      $display("FAIL walloc_word0 got=%h lat=%0d exp a5a50060/0", rd, lat); end
    checks++;
    if (both_high) begin errors++; $display("FAIL pmem_exclusive got=both_high exp=never"); end
  endtask

  initial begin
    pm[32'h100] = 256'hDEADBEEF << 32;
    test_reset();
    test_cold_read_miss();
    test_write_hit();
    test_dirty_eviction();
    test_reset_during_fill();
    test_zero_be_write();
    test_read_write_both();
    test_write_allocate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
